// File: rtl/id_ex_pipe_if.sv
// Decode-to-execute payload bus: id side is driven by decode, ex side by the ID/EX register.
interface id_ex_pipe_if #(
    parameter int PAYLOAD_W = 87
);
    logic [PAYLOAD_W-1:0] id_payload;
    logic                 id_valid;
    logic [PAYLOAD_W-1:0] ex_payload;
    logic                 ex_valid;

    modport master (output id_payload, output id_valid, input ex_payload, input ex_valid);
    modport slave  (input id_payload, input id_valid, output ex_payload, output ex_valid);
endinterface

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with valid/flush, stall-count passthrough and saturating perf counters.
//
// action  | meaning
// --------+-----------------------------------------------------------------
// PAUSE   | rdy=0: every register holds
// FLUSH   | kill held instruction, drive NOP, count if a valid one was killed
// BUBBLE  | own stall, downstream running: insert NOP, pass cnt_i
// HOLD    | own and downstream stalled: keep payload, pass cnt_i
// CAPTURE | own running: take decode output (NOP when not valid), clear cnt_o
module id_ex_pipe #(
    parameter int                   PAYLOAD_W   = 87,
    parameter logic [PAYLOAD_W-1:0] NOP_PAYLOAD = '0,
    parameter int                   STALL_W     = 6,
    parameter int                   STAGE       = 2,
    parameter int                   CNT_W       = 2,
    parameter int                   PERF_W      = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rdy,
    input  logic [STALL_W-1:0] stall_sign,
    input  logic               flush,
    input  logic [CNT_W-1:0]   cnt_i,
    id_ex_pipe_if.slave        pipe_if,
    output logic [CNT_W-1:0]   cnt_o,
    output logic [PERF_W-1:0]  perf_bubble,
    output logic [PERF_W-1:0]  perf_hold,
    output logic [PERF_W-1:0]  perf_flush
);

    logic                 own_stall;
    logic                 down_stall;
    logic                 stall_unused;

    logic [PAYLOAD_W-1:0] payload_q, payload_d;
    logic                 valid_q, valid_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [PERF_W-1:0]    bubble_q, bubble_d;
    logic [PERF_W-1:0]    hold_q, hold_d;
    logic [PERF_W-1:0]    flush_cnt_q, flush_cnt_d;

    assign own_stall    = stall_sign[STAGE];
    assign down_stall   = stall_sign[STAGE+1];
    // Other stages' stall bits belong to their own registers.
    assign stall_unused = ^stall_sign;

    always_comb begin
        payload_d   = payload_q;
        valid_d     = valid_q;
        cnt_d       = cnt_q;
        bubble_d    = bubble_q;
        hold_d      = hold_q;
        flush_cnt_d = flush_cnt_q;
        if (!rdy) begin
            payload_d = payload_q;
        end else if (flush) begin
            payload_d = NOP_PAYLOAD;
            valid_d   = 1'b0;
            cnt_d     = '0;
            if (valid_q) begin
                flush_cnt_d = flush_cnt_q + {{(PERF_W-1){1'b0}}, ~&flush_cnt_q};
            end
        end else if (own_stall && !down_stall) begin
            payload_d = NOP_PAYLOAD;
            valid_d   = 1'b0;
            cnt_d     = cnt_i;
            bubble_d  = bubble_q + {{(PERF_W-1){1'b0}}, ~&bubble_q};
        end else if (own_stall && down_stall) begin
            cnt_d  = cnt_i;
            hold_d = hold_q + {{(PERF_W-1){1'b0}}, ~&hold_q};
        end else begin
            // own=0 with down=1 is a ctrl protocol error and lands here as a capture.
            payload_d = pipe_if.id_valid ? pipe_if.id_payload : NOP_PAYLOAD;
            valid_d   = pipe_if.id_valid;
            cnt_d     = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            payload_q   <= NOP_PAYLOAD;
            valid_q     <= 1'b0;
            cnt_q       <= '0;
            bubble_q    <= '0;
            hold_q      <= '0;
            flush_cnt_q <= '0;
        end else begin
            payload_q   <= payload_d;
            valid_q     <= valid_d;
            cnt_q       <= cnt_d;
            bubble_q    <= bubble_d;
            hold_q      <= hold_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign pipe_if.ex_payload = payload_q;
    assign pipe_if.ex_valid   = valid_q;
    assign cnt_o              = cnt_q;
    assign perf_bubble        = bubble_q;
    assign perf_hold          = hold_q;
    assign perf_flush         = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_pipe.sv
// Directed bench for id_ex_pipe: default instance plus a PERF_W=4 / STAGE=3 variant.
`timescale 1ns/1ps
module tb_id_ex_pipe;

    localparam int PW = 87;
    localparam logic [PW-1:0] P1 = 87'h12_3456_789A_BCDE_F012_3456;
    localparam logic [PW-1:0] P2 = 87'h7E_DCBA_9876_5432_10FE_DCBA;
    localparam logic [PW-1:0] P3 = 87'h00_0000_0001_0000_0000_0033;
    localparam logic [PW-1:0] P4 = 87'h55_AAAA_5555_AAAA_5555_AAAA;
    localparam logic [PW-1:0] P5 = 87'h2A_1111_2222_3333_4444_5555;
    localparam logic [PW-1:0] ONES = '1;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        flush;
    logic [1:0]  cnt_i;
    logic [5:0]  stall0, stall1;
    logic [1:0]  cnt_o0, cnt_o1;
    logic [15:0] bub0, hold0, fl0;
    logic [3:0]  bub1, hold1, fl1;

    int vectors = 0;
    int miscompares = 0;

    id_ex_pipe_if #(.PAYLOAD_W(PW)) if0 ();
    id_ex_pipe_if #(.PAYLOAD_W(PW)) if1 ();

    id_ex_pipe dut0 (
        .clk(clk), .rst(rst), .rdy(rdy), .stall_sign(stall0), .flush(flush), .cnt_i(cnt_i),
        .pipe_if(if0.slave), .cnt_o(cnt_o0), .perf_bubble(bub0), .perf_hold(hold0), .perf_flush(fl0)
    );

    id_ex_pipe #(.PERF_W(4), .STAGE(3)) dut1 (
        .clk(clk), .rst(rst), .rdy(rdy), .stall_sign(stall1), .flush(flush), .cnt_i(cnt_i),
        .pipe_if(if1.slave), .cnt_o(cnt_o1), .perf_bubble(bub1), .perf_hold(hold1), .perf_flush(fl1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst === 1'b0) begin
            assert (!(stall0[2] === 1'b0 && stall0[3] === 1'b1)) else $error("stall protocol error dut0");
            assert (!(stall1[3] === 1'b0 && stall1[4] === 1'b1)) else $error("stall protocol error dut1");
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_id(input logic [PW-1:0] p, input logic v);
        if0.id_payload = p;
        if0.id_valid   = v;
        if1.id_payload = p;
        if1.id_valid   = v;
    endtask

    task automatic test_reset;
        drive_id(ONES, 1'b1);
        rst = 1'b1; rdy = 1'b1; flush = 1'b1; cnt_i = 2'd3;
        stall0 = 6'b100101; stall1 = 6'b100101;
        tick();
        vectors++;
        if (if0.ex_payload !== '0) begin
            miscompares++; $display("FAIL reset_payload got=%h exp=0", if0.ex_payload);
        end
        vectors++;
        if ({if0.ex_valid, cnt_o0} !== 3'b000) begin
            miscompares++; $display("FAIL reset_valid_cnt got=%b exp=000", {if0.ex_valid, cnt_o0});
        end
        vectors++;
        if ({bub0, hold0, fl0} !== 48'd0) begin
            miscompares++; $display("FAIL reset_perf got=%h/%h/%h exp=0/0/0", bub0, hold0, fl0);
        end
        rdy = 1'b0;
        tick();
        vectors++;
        if ({if0.ex_payload, if0.ex_valid, cnt_o0, bub0, hold0, fl0} !== '0) begin
            miscompares++; $display("FAIL reset_with_pause got payload=%h valid=%b cnt=%0d exp all 0",
                                    if0.ex_payload, if0.ex_valid, cnt_o0);
        end
        rst = 1'b0; rdy = 1'b1; flush = 1'b0; stall0 = '0; stall1 = '0;
    endtask

    task automatic test_capture;
        logic [PW-1:0] seq [3];
        seq[0] = P1; seq[1] = P2; seq[2] = P3;
        cnt_i = 2'd3;
        for (int i = 0; i < 3; i++) begin
            drive_id(seq[i], 1'b1);
            tick();
            vectors++;
            if (if0.ex_payload !== seq[i]) begin
                miscompares++; $display("FAIL capture_payload[%0d] got=%h exp=%h", i, if0.ex_payload, seq[i]);
            end
            vectors++;
            if ({if0.ex_valid, cnt_o0} !== 3'b100) begin
                miscompares++; $display("FAIL capture_valid_cnt[%0d] got=%b exp=100", i, {if0.ex_valid, cnt_o0});
            end
        end
        drive_id(ONES, 1'b0);
        tick();
        vectors++;
        if ({if0.ex_valid, if0.ex_payload} !== '0) begin
            miscompares++; $display("FAIL capture_invalid got valid=%b payload=%h exp 0/0", if0.ex_valid, if0.ex_payload);
        end
    endtask

    task automatic test_bubble_hold;
        drive_id(P2, 1'b1);
        stall0 = 6'b000100; cnt_i = 2'd1;
        tick();
        vectors++;
        if ({if0.ex_valid, if0.ex_payload, cnt_o0, bub0} !== {1'b0, 87'd0, 2'd1, 16'd1}) begin
            miscompares++; $display("FAIL bubble got valid=%b payload=%h cnt=%0d bub=%0d exp 0/0/1/1",
                                    if0.ex_valid, if0.ex_payload, cnt_o0, bub0);
        end
        stall0 = '0; drive_id(P4, 1'b1);
        tick();
        vectors++;
        if ({if0.ex_valid, if0.ex_payload, cnt_o0} !== {1'b1, P4, 2'd0}) begin
            miscompares++; $display("FAIL capture_p4 got valid=%b payload=%h cnt=%0d", if0.ex_valid, if0.ex_payload, cnt_o0);
        end
        stall0 = 6'b001100; drive_id(P5, 1'b1);
        for (int i = 1; i <= 3; i++) begin
            cnt_i = 2'(i);
            tick();
            vectors++;
            if ({if0.ex_valid, if0.ex_payload, cnt_o0} !== {1'b1, P4, 2'(i)}) begin
                miscompares++; $display("FAIL hold[%0d] got valid=%b payload=%h cnt=%0d exp 1/%h/%0d",
                                        i, if0.ex_valid, if0.ex_payload, cnt_o0, P4, i);
            end
        end
        vectors++;
        if ({hold0, bub0} !== {16'd3, 16'd1}) begin
            miscompares++; $display("FAIL hold_count got hold=%0d bub=%0d exp 3/1", hold0, bub0);
        end
        stall0 = '0;
    endtask

    task automatic test_flush;
        drive_id(P5, 1'b1); cnt_i = 2'd2;
        tick();
        stall0 = 6'b001100; flush = 1'b1;
        tick();
        vectors++;
        if ({if0.ex_valid, if0.ex_payload, cnt_o0} !== '0) begin
            miscompares++; $display("FAIL flush_out got valid=%b payload=%h cnt=%0d exp 0/0/0",
                                    if0.ex_valid, if0.ex_payload, cnt_o0);
        end
        vectors++;
        if ({fl0, hold0, bub0} !== {16'd1, 16'd3, 16'd1}) begin
            miscompares++; $display("FAIL flush_perf got fl=%0d hold=%0d bub=%0d exp 1/3/1", fl0, hold0, bub0);
        end
        tick();
        vectors++;
        if (fl0 !== 16'd1) begin
            miscompares++; $display("FAIL flush_idle got fl=%0d exp 1", fl0);
        end
        flush = 1'b0; stall0 = '0;
    endtask

    task automatic test_pause;
        logic [PW-1:0] seq [4];
        seq[0] = P2; seq[1] = P3; seq[2] = P4; seq[3] = P5;
        drive_id(P1, 1'b1);
        tick();
        rdy = 1'b0; flush = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_id(seq[i], i[0]);
            stall0 = i[0] ? 6'b001100 : 6'b000100;
            cnt_i  = 2'(i);
            tick();
            vectors++;
            if ({if0.ex_valid, if0.ex_payload, cnt_o0, bub0, hold0, fl0} !==
                {1'b1, P1, 2'd0, 16'd1, 16'd3, 16'd1}) begin
                miscompares++; $display("FAIL pause[%0d] got valid=%b payload=%h cnt=%0d bub=%0d hold=%0d fl=%0d",
                                        i, if0.ex_valid, if0.ex_payload, cnt_o0, bub0, hold0, fl0);
            end
        end
        rdy = 1'b1;
        tick();
        vectors++;
        if ({if0.ex_valid, if0.ex_payload, fl0} !== {1'b0, 87'd0, 16'd2}) begin
            miscompares++; $display("FAIL pause_resume got valid=%b payload=%h fl=%0d exp 0/0/2",
                                    if0.ex_valid, if0.ex_payload, fl0);
        end
        flush = 1'b0; stall0 = '0;
    endtask

    task automatic test_reset_mid_stall;
        drive_id(P2, 1'b1); cnt_i = 2'd3;
        tick();
        stall0 = 6'b001100;
        tick();
        rst = 1'b1; rdy = 1'b0;
        tick();
        vectors++;
        if ({if0.ex_valid, if0.ex_payload, cnt_o0, bub0, hold0, fl0} !== '0) begin
            miscompares++; $display("FAIL reset_mid_stall got valid=%b payload=%h cnt=%0d hold=%0d exp all 0",
                                    if0.ex_valid, if0.ex_payload, cnt_o0, hold0);
        end
        rst = 1'b0; rdy = 1'b1; stall0 = '0;
    endtask

    task automatic test_saturation;
        drive_id(P3, 1'b1); stall1 = '0;
        tick();
        stall1 = 6'b011000; drive_id(P1, 1'b1);
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 15 || i == 20) begin
                vectors++;
                if ({hold1, if1.ex_valid, if1.ex_payload} !== {4'd15, 1'b1, P3}) begin
                    miscompares++; $display("FAIL saturate[%0d] got hold=%0d valid=%b payload=%h exp 15/1/%h",
                                            i, hold1, if1.ex_valid, if1.ex_payload, P3);
                end
            end
        end
        stall1 = '0;
    endtask

    task automatic test_variant;
        stall1 = '0; stall0 = '0; cnt_i = 2'd2;
        drive_id(P4, 1'b1);
        tick();
        vectors++;
        if ({if1.ex_valid, if1.ex_payload, cnt_o1} !== {1'b1, P4, 2'd0}) begin
            miscompares++; $display("FAIL variant_capture got valid=%b payload=%h cnt=%0d", if1.ex_valid, if1.ex_payload, cnt_o1);
        end
        drive_id(P5, 1'b1);
        tick();
        vectors++;
        if (if1.ex_payload !== P5) begin
            miscompares++; $display("FAIL variant_capture2 got=%h exp=%h", if1.ex_payload, P5);
        end
        stall1 = 6'b001000;
        tick();
        vectors++;
        if ({if1.ex_valid, cnt_o1, bub1, if0.ex_payload} !== {1'b0, 2'd2, 4'd1, P5}) begin
            miscompares++; $display("FAIL variant_bubble got valid=%b cnt=%0d bub=%0d dut0_payload=%h",
                                    if1.ex_valid, cnt_o1, bub1, if0.ex_payload);
        end
        stall1 = '0;
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; flush = 1'b0; cnt_i = '0;
        stall0 = '0; stall1 = '0;
        drive_id('0, 1'b0);
        test_reset();
        test_capture();
        test_bubble_hold();
        test_flush();
        test_pause();
        test_reset_mid_stall();
        test_saturation();
        test_variant();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/id_ex_pipe.md
Name: id_ex_pipe

Overview:
- Parametrised ID/EX pipeline register for the in-order core. Carries a packed decode payload (opcode, funct3, funct7, operands, destination, write-enable) from decode to execute.
- Generalises the current ID/EX latch with:
  - configurable payload width and stage position on the stall bus;
  - an explicit valid bit and a flush input that kills the held instruction;
  - a configurable stall-count passthrough;
  - saturating performance counters for bubbles, holds and flushes.
- Sits between id and ex; driven by ctrl (stall bus, flush) and the global rdy pause.

Parameters:
- PAYLOAD_W, 87, width of packed payload: opcode 7 + funct3 3 + funct7 7 + reg1 32 + reg2 32 + wd 5 + wreg 1.
- NOP_PAYLOAD, 87'd0, payload driven on reset, bubble and flush (encodes NON_OP, zero operands, NOPRegAddr, WriteDisable).
- STALL_W, 6, width of stall_sign bus.
- STAGE, 2, index of this stage's bit in stall_sign; bit STAGE+1 is the downstream stage. Requires STAGE+1 < STALL_W.
- CNT_W, 2, width of the stall-count passthrough (cnt_i/cnt_o).
- PERF_W, 16, width of each performance counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- rdy  in  1  global run enable. 1 = pipeline may advance; 0 = full pause, all state frozen.
- stall_sign  in  STALL_W  ctrl stall bus, one bit per stage.
- flush  in  1  kill the instruction held in this register (branch/jump redirect from ex).
- cnt_i  in  CNT_W  stall-count value from ctrl.
- id_payload  in  PAYLOAD_W  packed decode output.
- id_valid  in  1  decode presents a real instruction.
- ex_payload  out  PAYLOAD_W  registered payload to ex.
- ex_valid  out  1  ex_payload is a real instruction.
- cnt_o  out  CNT_W  registered stall-count back to ctrl.
- perf_bubble  out  PERF_W  bubbles inserted (saturating).
- perf_hold  out  PERF_W  cycles held by downstream stall (saturating).
- perf_flush  out  PERF_W  flushes that killed a valid instruction (saturating).

Behaviour:
- Reset: all outputs are registered and update only on posedge clk.
  - rst=1 at an edge: ex_payload=NOP_PAYLOAD, ex_valid=0, cnt_o=0, all perf counters = 0.
  - rst has priority over every other input, including rdy=0. Reset mid-stall or mid-flush discards all state.
- Stall decoding: own = stall_sign[STAGE], down = stall_sign[STAGE+1].
- Per-edge actions when rst=0, first match wins:
  1. rdy=0 (PAUSE): every register holds, including cnt_o and perf counters.
  2. flush=1 (FLUSH): ex_payload=NOP_PAYLOAD, ex_valid=0, cnt_o=0.
     - perf_flush increments if ex_valid was 1.
     - Flush overrides stall; a simultaneous flush and stall yields a bubble, not a hold.
  3. own=1 and down=0 (BUBBLE): ex_payload=NOP_PAYLOAD, ex_valid=0, cnt_o=cnt_i, perf_bubble increments.
  4. own=1 and down=1 (HOLD): ex_payload and ex_valid hold, cnt_o=cnt_i, perf_hold increments.
  5. own=0 (CAPTURE): ex_payload=id_payload, ex_valid=id_valid, cnt_o=0.
     - If id_valid=0, ex_payload=NOP_PAYLOAD, so no stray wreg reaches ex.
- own=0 with down=1 is a ctrl protocol error. The block treats it as CAPTURE. The testbench asserts that it never occurs.
- Latency: exactly 1 cycle from id_payload to ex_payload in CAPTURE; 0 combinational paths from inputs to outputs.
- Perf counters:
  - Saturate at 2^PERF_W-1; no wrap.
  - At most one counter increments per cycle.
  - Frozen when rdy=0.
- cnt_o is the registered cnt_i, not incremented here; ctrl owns counting. The CAPTURE clear lets ctrl detect stall release.
- ex_valid is the only qualifier ex uses; ex_payload contents with ex_valid=0 are NOP_PAYLOAD in every case.

Test Plan:
- Reset: drive garbage inputs, assert rst for 2 cycles, including one with rdy=0 -> ex_payload=0, ex_valid=0, cnt_o=0, perf_* = 0 after the first reset edge.
- Capture stream: rdy=1, stall=0, id_payload=P1,P2,P3 with id_valid=1 on consecutive cycles -> ex_payload=P1,P2,P3 one cycle later with ex_valid=1, cnt_o=0; id_valid=0 with payload 0x7F... -> ex_payload=0.
- Bubble vs hold: stall_sign=6'b000100 with cnt_i=2'b01 -> bubble, ex_valid=0, cnt_o=1, perf_bubble=1. Then stall_sign=6'b001100 for 3 cycles with P4 held -> P4 stable, perf_hold=3, cnt_o tracks cnt_i.
- Flush priority: P5 held under stall_sign=6'b001100, assert flush the same cycle -> ex_payload=0, ex_valid=0, cnt_o=0, perf_flush=1, perf_hold unchanged. A flush while ex_valid=0 leaves perf_flush unchanged.
- Pause: rdy=0 for 4 cycles while id_payload changes, stall toggles and flush=1 -> all outputs and counters frozen; on rdy=1 the next edge resumes per the priority list.
- Saturation: PERF_W=4, hold 20 cycles -> perf_hold stops at 15; PERF_W=4 and STAGE=3 variants elaborate and pass the capture test.
